// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// No logic; no latency; no backpressure.
// Holds the zero-register index and the packed-port slicing helper.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    // Low bit of port `idx` inside a bus packed as NUM_RD fields of `width` bits.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: zero register, write-through bypass and busy masking.
// Latency: purely combinational.
// Backpressure: none; the port always answers in the same cycle.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_act,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              busy_bit,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic is_zero;
    logic wr_hit;

    assign is_zero = (rd_addr == ADDR_W'(REG_ZERO));
    assign wr_hit  = (BYPASS != 0) && wr_act && (wr_addr == rd_addr);

    always_comb begin
        rd_data = arr_data;
        rd_busy = busy_bit;
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (wr_hit) begin
            // Producer retires this cycle, so the consumer no longer has to wait.
            rd_data = wr_data;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// N-read / 1-write register file with hardwired r0 and a per-register busy scoreboard.
// Latency: reads combinational, writes and busy updates land on the next rising edge.
// Backpressure: none; decode stalls itself by watching rd_busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr_act;
    logic              wr_ok;
    logic              mark_ok;

    // Bypass must stay silent while in reset so every port reads zero.
    assign wr_act  = wr_en & rst_n;
    assign wr_ok   = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
    assign mark_ok = mark_en && (mark_addr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Mark is applied after the clear so a newer producer wins over a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (mark_ok) begin
            busy_nxt[mark_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;

        assign addr = rd_addr[slice_lo(g, ADDR_W) +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_port (
            .rd_addr  (addr),
            .wr_act   (wr_act),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .arr_data (mem[addr]),
            .busy_bit (busy[addr]),
            .rd_data  (rd_data[slice_lo(g, DATA_W) +: DATA_W]),
            .rd_busy  (rd_busy[g])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: default (bypass), no-bypass and 4-port/64-bit instances.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mark_en;
    logic [4:0]  mark_addr;
    logic        flush;
    logic [5:0]  busy_cnt;
    logic [5:0]  nb_busy_cnt;

    logic [19:0]  w_rd_addr;
    logic [255:0] w_rd_data;
    logic [3:0]   w_rd_busy;
    logic         w_wr_en;
    logic [4:0]   w_wr_addr;
    logic [63:0]  w_wr_data;
    logic         w_mark_en;
    logic [4:0]   w_mark_addr;
    logic         w_flush;
    logic [5:0]   w_busy_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en),
        .mark_addr(mark_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en),
        .mark_addr(mark_addr), .flush(flush), .busy_cnt(nb_busy_cnt)
    );

    regfile_sb #(.DATA_W(64), .NUM_RD(4)) u_wide (
        .clk(clk), .rst_n(rst_n), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .mark_en(w_mark_en),
        .mark_addr(w_mark_addr), .flush(w_flush), .busy_cnt(w_busy_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        mark_en = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        mark_en = 1'b0; mark_addr = '0; flush = 1'b0;
        w_rd_addr = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        w_mark_en = 1'b0; w_mark_addr = '0; w_flush = 1'b0;

        // Reset: bypass ignored, everything reads zero.
        #2;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_0000; rd_addr = {5'd0, 5'd5};
        #10;
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_rd_busy", {62'h0, rd_busy}, 64'h0);
        chk("rst_busy_cnt", {58'h0, busy_cnt}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Write r5, read back next cycle.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd0};
        @(negedge clk);
        idle(); rd_addr = {5'd0, 5'd5};
        #1;
        chk("r5_readback", {32'h0, rd_data[31:0]}, 64'hDEAD_BEEF);
        chk("r5_readback_nb", {32'h0, nb_rd_data[31:0]}, 64'hDEAD_BEEF);

        // Mid-run reset clears immediately.
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_data", {32'h0, rd_data[31:0]}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_r5_after", {32'h0, rd_data[31:0]}, 64'h0);

        // Writes to r0 are dropped.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; rd_addr = {5'd0, 5'd0};
        #1;
        chk("r0_same_cycle", rd_data, 64'h0);
        @(negedge clk);
        idle();
        #1;
        chk("r0_after", rd_data, 64'h0);
        chk("r0_busy_cnt", {58'h0, busy_cnt}, 64'h0);

        // Read-during-write, with and without bypass.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111; rd_addr = {5'd0, 5'd0};
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; rd_addr = {5'd7, 5'd0};
        #1;
        chk("byp_same_cycle", {32'h0, rd_data[63:32]}, 64'hA5A5_A5A5);
        chk("nobyp_same_cycle", {32'h0, nb_rd_data[63:32]}, 64'h1111_1111);
        @(negedge clk);
        idle();
        #1;
        chk("byp_next_cycle", {32'h0, rd_data[63:32]}, 64'hA5A5_A5A5);
        chk("nobyp_next_cycle", {32'h0, nb_rd_data[63:32]}, 64'hA5A5_A5A5);

        // Mark r3, observe busy, retire it by a write.
        @(negedge clk);
        mark_en = 1'b1; mark_addr = 5'd3; rd_addr = {5'd0, 5'd3};
        #1;
        chk("mark_not_yet", {63'h0, rd_busy[0]}, 64'h0);
        @(negedge clk);
        idle();
        #1;
        chk("mark_visible", {63'h0, rd_busy[0]}, 64'h1);
        chk("mark_cnt", {58'h0, busy_cnt}, 64'h1);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        chk("retire_byp_busy", {63'h0, rd_busy[0]}, 64'h0);
        chk("retire_nobyp_busy", {63'h0, nb_rd_busy[0]}, 64'h1);
        chk("retire_cnt_before", {58'h0, busy_cnt}, 64'h1);
        @(negedge clk);
        idle();
        #1;
        chk("retire_cnt_after", {58'h0, busy_cnt}, 64'h0);
        chk("retire_busy_after", {63'h0, rd_busy[0]}, 64'h0);

        // Same-cycle mark and write: the mark wins.
        @(negedge clk);
        mark_en = 1'b1; mark_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        rd_addr = {5'd0, 5'd0};
        @(negedge clk);
        idle(); rd_addr = {5'd10, 5'd9};
        #1;
        chk("mark_wins_busy", {63'h0, rd_busy[0]}, 64'h1);
        chk("mark_wins_cnt", {58'h0, busy_cnt}, 64'h1);
        chk("mark_wins_data", {32'h0, rd_data[31:0]}, 64'h99);

        // Flush beats a same-cycle mark, but the array write still lands.
        @(negedge clk);
        flush = 1'b1; mark_en = 1'b1; mark_addr = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hC;
        @(negedge clk);
        idle(); rd_addr = {5'd10, 5'd9};
        #1;
        chk("flush_cnt", {58'h0, busy_cnt}, 64'h0);
        chk("flush_rd_busy", {62'h0, rd_busy}, 64'h0);
        rd_addr = {5'd0, 5'd12};
        #1;
        chk("flush_wr_lands", {32'h0, rd_data[31:0]}, 64'hC);

        // Count of distinct busy registers, re-marking does not double count.
        @(negedge clk);
        mark_en = 1'b1; mark_addr = 5'd1;
        @(negedge clk);
        mark_addr = 5'd2;
        @(negedge clk);
        mark_addr = 5'd1;
        @(negedge clk);
        idle();
        #1;
        chk("cnt_two", {58'h0, busy_cnt}, 64'h2);

        // Wide instance: four ports, duplicate addresses and r0.
        @(negedge clk);
        w_wr_en = 1'b1; w_wr_addr = 5'd1; w_wr_data = 64'h1;
        @(negedge clk);
        w_wr_addr = 5'd2; w_wr_data = 64'h2;
        @(negedge clk);
        w_wr_en = 1'b0; w_rd_addr = {5'd0, 5'd2, 5'd1, 5'd1};
        #1;
        chk("wide_p0", w_rd_data[63:0], 64'h1);
        chk("wide_p1", w_rd_data[127:64], 64'h1);
        chk("wide_p2", w_rd_data[191:128], 64'h2);
        chk("wide_p3", w_rd_data[255:192], 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
